spi_master_duplex: RTL and testbench

- Parametrised, full-duplex SPI master. It supersedes the fixed-mode, transmit-only serializer used for the DAC/galvo path.
- Adds configurable word width, clock divider, CPOL/CPHA mode, bit order, multiple chip selects, MISO capture and a one-cycle completion strobe.
- Sits between control FSMs (laser/DAC drivers, network-config readers) and off-chip SPI peripherals.

---
 rtl/spi_master_duplex.sv | 216 +++++++++++++++++++++
 tb/tb_spi_master_duplex.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master with configurable word width, divider, CPOL/CPHA, bit order and chip selects.
// Each transfer is a setup period, len bits of two half-periods each, then a hold period, all counted in CLK_DIV units.
module spi_master_duplex #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CLK_DIV    = 500,
   parameter int unsigned CPOL       = 0,
   parameter int unsigned CPHA       = 0,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned NUM_CS     = 1
) (
   input  logic                                      clock_in,
   input  logic                                      reset_in,
   input  logic [DATA_WIDTH-1:0]                     data_in,
   input  logic [$clog2(DATA_WIDTH+1)-1:0]           data_length_in,
   input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel_in,
   input  logic                                      start_in,
   input  logic                                      miso_in,
   output logic                                      busy_out,
   output logic                                      done_out,
   output logic [DATA_WIDTH-1:0]                     rx_data_out,
   output logic                                      sclk_out,
   output logic                                      mosi_out,
   output logic [NUM_CS-1:0]                         cs_out
);

   localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic        IDLE_LVL = 1'(CPOL);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  half_q, half_d;
   logic [LEN_W-1:0]      bit_q, bit_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rxsr_q, rxsr_d;

   logic                  busy_d, done_d, sclk_d, mosi_d;
   logic [NUM_CS-1:0]     cs_d;
   logic [DATA_WIDTH-1:0] rx_d;

   logic                  div_end;
   logic                  last_bit;
   logic                  do_drive, do_sample;
   logic [LEN_W-1:0]      len_sat;
   logic [DATA_WIDTH-1:0] tx_aligned;
   logic [DATA_WIDTH-1:0] rx_shifted;
   logic [DATA_WIDTH-1:0] rx_final;
   logic [NUM_CS-1:0]     sel_mask;

   // Bit that goes on the wire next, and the register after it has gone.
   function automatic logic tx_head(input logic [DATA_WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] tx_next(input logic [DATA_WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
   endfunction

   assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));
   assign last_bit = (bit_q == (len_q - LEN_W'(1)));
   assign len_sat  = (data_length_in > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : data_length_in;

   // MSB-first words are left-aligned so the first bit always sits at the top.
   assign tx_aligned = (MSB_FIRST != 0) ? (data_in << (LEN_W'(DATA_WIDTH) - len_sat)) : data_in;

   assign rx_shifted = (MSB_FIRST != 0) ? {rxsr_q[DATA_WIDTH-2:0], miso_in}
                                        : {miso_in, rxsr_q[DATA_WIDTH-1:1]};
   assign rx_final   = (MSB_FIRST != 0) ? rxsr_q : (rxsr_q >> (LEN_W'(DATA_WIDTH) - len_q));

   // Active-low select pattern; an out-of-range selector leaves every line high.
   always_comb begin
      sel_mask = '1;
      for (int i = 0; i < int'(NUM_CS); i++) begin
         if (int'(cs_sel_in) == i) begin
            sel_mask[i] = 1'b0;
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      half_d    = half_q;
      bit_d     = bit_q;
      len_d     = len_q;
      tx_d      = tx_q;
      rxsr_d    = rxsr_q;
      busy_d    = busy_out;
      done_d    = 1'b0;
      sclk_d    = sclk_out;
      mosi_d    = mosi_out;
      cs_d      = cs_out;
      rx_d      = rx_data_out;
      do_drive  = 1'b0;
      do_sample = 1'b0;

      if (state_q != ST_IDLE) begin
         div_d = div_end ? '0 : (div_q + DIV_W'(1));
      end

      case (state_q)
         ST_IDLE: begin
            if (start_in && !busy_out && (len_sat != '0)) begin
               state_d = ST_SETUP;
               div_d   = '0;
               half_d  = 1'b0;
               bit_d   = '0;
               len_d   = len_sat;
               rxsr_d  = '0;
               busy_d  = 1'b1;
               cs_d    = sel_mask;
               if (CPHA == 0) begin
                  mosi_d = tx_head(tx_aligned);
                  tx_d   = tx_next(tx_aligned);
               end else begin
                  tx_d   = tx_aligned;
               end
            end
         end
         ST_SETUP: begin
            if (div_end) begin
               state_d = ST_SHIFT;
               half_d  = 1'b0;
               bit_d   = '0;
               sclk_d  = ~IDLE_LVL;
               if (CPHA == 0) do_sample = 1'b1;
               else           do_drive  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (div_end) begin
               if (!half_q) begin
                  // Trailing edge.
                  half_d = 1'b1;
                  sclk_d = IDLE_LVL;
                  if (CPHA == 0) do_drive  = !last_bit;
                  else           do_sample = 1'b1;
               end else if (last_bit) begin
                  state_d = ST_HOLD;
               end else begin
                  // Leading edge of the next bit.
                  half_d = 1'b0;
                  bit_d  = bit_q + LEN_W'(1);
                  sclk_d = ~IDLE_LVL;
                  if (CPHA == 0) do_sample = 1'b1;
                  else           do_drive  = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (div_end) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cs_d    = '1;
               mosi_d  = 1'b0;
               rx_d    = rx_final;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_drive) begin
         mosi_d = tx_head(tx_q);
         tx_d   = tx_next(tx_q);
      end
      if (do_sample) begin
         rxsr_d = rx_shifted;
      end
   end

   // State and output registers.
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         half_q      <= 1'b0;
         bit_q       <= '0;
         len_q       <= '0;
         tx_q        <= '0;
         rxsr_q      <= '0;
         busy_out    <= 1'b0;
         done_out    <= 1'b0;
         rx_data_out <= '0;
         sclk_out    <= IDLE_LVL;
         mosi_out    <= 1'b0;
         cs_out      <= '1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         half_q      <= half_d;
         bit_q       <= bit_d;
         len_q       <= len_d;
         tx_q        <= tx_d;
         rxsr_q      <= rxsr_d;
         busy_out    <= busy_d;
         done_out    <= done_d;
         rx_data_out <= rx_d;
         sclk_out    <= sclk_d;
         mosi_out    <= mosi_d;
         cs_out      <= cs_d;
      end
   end

endmodule

// File: tb/tb_spi_master_duplex.sv
// Bench for spi_master_duplex: two instances (mode 0 / 4 CS, and CPOL=1 CPHA=1 LSB-first),
// checked every cycle against a time-indexed waveform model plus literal expectations.
module tb_spi_master_duplex;

   logic clk;
   logic rst_n;

   logic [15:0] d0, d1;
   logic [4:0]  l0, l1;
   logic [1:0]  s0;
   logic        s1;
   logic        st0, st1;
   logic [1:0]  mm0, mm1;
   logic        mi0, mi1;
   logic        bz0, dn0, sc0, mo0, bz1, dn1, sc1, mo1;
   logic [15:0] rx0, rx1;
   logic [3:0]  cs0;
   logic        cs1;

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  chk_en  = 0;

   // miso mode: 0 = tied low, 1 = tied high, 2 = looped back from mosi
   assign mi0 = (mm0 == 2'd2) ? mo0 : mm0[0];
   assign mi1 = (mm1 == 2'd2) ? mo1 : mm1[0];

   spi_master_duplex #(.DATA_WIDTH(16), .CLK_DIV(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .NUM_CS(4)) u0 (
      .clock_in(clk), .reset_in(rst_n), .data_in(d0), .data_length_in(l0), .cs_sel_in(s0),
      .start_in(st0), .miso_in(mi0), .busy_out(bz0), .done_out(dn0), .rx_data_out(rx0),
      .sclk_out(sc0), .mosi_out(mo0), .cs_out(cs0));

   spi_master_duplex #(.DATA_WIDTH(16), .CLK_DIV(3), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .NUM_CS(1)) u1 (
      .clock_in(clk), .reset_in(rst_n), .data_in(d1), .data_length_in(l1), .cs_sel_in(s1),
      .start_in(st1), .miso_in(mi1), .busy_out(bz1), .done_out(dn1), .rx_data_out(rx1),
      .sclk_out(sc1), .mosi_out(mo1), .cs_out(cs1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_act[2]  = '{0, 0};
   bit          m_done[2] = '{0, 0};
   int          m_t[2]    = '{0, 0};
   int          m_len[2]  = '{0, 0};
   int          m_sel[2]  = '{0, 0};
   logic [15:0] m_data[2] = '{16'h0, 16'h0};
   logic [15:0] m_rx[2]   = '{16'h0, 16'h0};
   logic [1:0]  m_mm[2]   = '{2'd0, 2'd0};

   function automatic int p_div(input int k);  return (k == 0) ? 4 : 3; endfunction
   function automatic int p_cpol(input int k); return (k == 0) ? 0 : 1; endfunction
   function automatic int p_cpha(input int k); return (k == 0) ? 0 : 1; endfunction
   function automatic int p_msb(input int k);  return (k == 0) ? 1 : 0; endfunction
   function automatic int p_ncs(input int k);  return (k == 0) ? 4 : 1; endfunction

   function automatic logic [15:0] len_mask(input int L);
      logic [16:0] m;
      m = (17'd1 << L) - 17'd1;
      return m[15:0];
   endfunction

   // Expected sclk/mosi during cycle t (t=1 is the first cycle after the accepting edge).
   function automatic void exp_wave(input int k, input int t, input int L, input logic [15:0] data,
                                    output logic es, output logic em);
      int D, p, q, i;
      bit h;
      logic b_i, b_n, b_last;
      D = p_div(k);
      p = t - 1;
      es = 1'(p_cpol(k));
      em = 1'b0;
      b_last = (p_msb(k) != 0) ? data[0] : data[L-1];
      if (p < D) begin
         if (p_cpha(k) == 0) em = (p_msb(k) != 0) ? data[L-1] : data[0];
      end else if (p < (2*L + 1) * D) begin
         q = p - D;
         i = q / (2*D);
         h = (q % (2*D)) >= D;
         b_i = (p_msb(k) != 0) ? data[L-1-i] : data[i];
         b_n = b_i;
         if (i < L - 1) b_n = (p_msb(k) != 0) ? data[L-2-i] : data[i+1];
         es = h ? 1'(p_cpol(k)) : ~1'(p_cpol(k));
         if (p_cpha(k) == 0) em = (h && i < L - 1) ? b_n : b_i;
         else                em = b_i;
      end else begin
         em = b_last;
      end
   endfunction

   task automatic model_step(input int k, input logic st, input logic [15:0] d, input logic [4:0] l,
                             input int s, input logic [1:0] mm);
      int B;
      if (!rst_n) begin
         m_act[k] = 0; m_done[k] = 0; m_t[k] = 0; m_rx[k] = 16'h0;
      end else begin
         m_done[k] = 0;
         if (m_act[k]) begin
            m_t[k]++;
            B = (2 * m_len[k] + 2) * p_div(k);
            if (m_t[k] == B + 1) begin
               m_act[k]  = 0;
               m_done[k] = 1;
               if (m_mm[k] == 2'd2)      m_rx[k] = m_data[k] & len_mask(m_len[k]);
               else if (m_mm[k] == 2'd1) m_rx[k] = len_mask(m_len[k]);
               else                      m_rx[k] = 16'h0;
            end
         end else if (st && l != 5'd0) begin
            m_act[k]  = 1;
            m_t[k]    = 1;
            m_len[k]  = (l > 5'd16) ? 16 : int'(l);
            m_data[k] = d;
            m_sel[k]  = s;
            m_mm[k]   = mm;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, st0, d0, l0, int'(s0), mm0);
      model_step(1, st1, d1, l1, int'(s1), mm1);
   end

   task automatic outs(input int k, output logic bz, output logic dn, output logic sc, output logic mo,
                       output logic [15:0] rx, output logic [3:0] cs);
      if (k == 0) begin bz = bz0; dn = dn0; sc = sc0; mo = mo0; rx = rx0; cs = cs0; end
      else        begin bz = bz1; dn = dn1; sc = sc1; mo = mo1; rx = rx1; cs = {3'b000, cs1}; end
   endtask

   task automatic compare(input int k);
      logic bz, dn, sc, mo, es, em;
      logic [15:0] rx;
      logic [3:0] cs, ecs;
      outs(k, bz, dn, sc, mo, rx, cs);
      es  = 1'(p_cpol(k));
      em  = 1'b0;
      ecs = 4'((1 << p_ncs(k)) - 1);
      if (m_act[k]) begin
         exp_wave(k, m_t[k], m_len[k], m_data[k], es, em);
         if (m_sel[k] < p_ncs(k)) ecs[m_sel[k]] = 1'b0;
      end
      check($sformatf("u%0d_busy", k), 32'(bz), 32'(m_act[k]));
      check($sformatf("u%0d_done", k), 32'(dn), 32'(m_done[k]));
      check($sformatf("u%0d_rx", k),   32'(rx), 32'(m_rx[k]));
      check($sformatf("u%0d_sclk", k), 32'(sc), 32'(es));
      check($sformatf("u%0d_mosi", k), 32'(mo), 32'(em));
      check($sformatf("u%0d_cs", k),   32'(cs), 32'(ecs));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         compare(0);
         compare(1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input int k, input logic st, input logic [15:0] d, input logic [4:0] l,
                        input int s, input logic [1:0] mm);
      if (k == 0) begin st0 = st; d0 = d; l0 = l; s0 = 2'(s); mm0 = mm; end
      else        begin st1 = st; d1 = d; l1 = l; s1 = 1'(s); mm1 = mm; end
   endtask

   // Scramble the request inputs without touching the miso mode.
   task automatic noise(input int k, input logic st);
      if (k == 0) begin st0 = st; d0 = 16'($urandom); l0 = 5'($urandom); s0 = 2'($urandom); end
      else        begin st1 = st; d1 = 16'($urandom); l1 = 5'($urandom); s1 = 1'($urandom); end
   endtask

   task automatic stop_start(input int k);
      if (k == 0) st0 = 1'b0; else st1 = 1'b0;
   endtask

   // Issue a request at the current negedge and follow it to its done cycle.
   task automatic xfer(input int k, input logic [15:0] d, input logic [4:0] l, input int s,
                       input logic [1:0] mm, input bit noisy,
                       output int bc, output int nl, output logic [15:0] bits,
                       output logic [3:0] cs_first, output logic [15:0] rx_done);
      int L, B;
      bit seen;
      logic prev, cpol, bz, dn, sc, mo;
      logic [15:0] rx;
      logic [3:0] cs;
      L = (l > 5'd16) ? 16 : int'(l);
      B = (2 * L + 2) * p_div(k);
      cpol = 1'(p_cpol(k));
      prev = cpol;
      seen = 0;
      bc = 0; nl = 0; bits = 16'h0; cs_first = 4'hF; rx_done = 16'h0;
      drive(k, 1'b1, d, l, s, mm);
      for (int c = 0; c < B + 20 && !seen; c++) begin
         @(negedge clk);
         outs(k, bz, dn, sc, mo, rx, cs);
         if (bz) bc++;
         if (c == 0) cs_first = cs;
         if (sc != prev && sc != cpol) begin
            nl++;
            bits = {bits[14:0], mo};
         end
         prev = sc;
         if (dn) begin
            seen = 1;
            rx_done = rx;
         end
         if (noisy && bz && bc < B - 2) noise(k, 1'($urandom_range(0, 3) == 0));
         else                           stop_start(k);
      end
      check($sformatf("u%0d_done_seen", k), 32'(seen), 32'd1);
   endtask

   initial begin
      int bc, nl, cnt;
      logic [15:0] bits, rxd;
      logic [3:0] csf;

      rst_n = 1'b0;
      drive(0, 1'b0, 16'h0, 5'd0, 0, 2'd2);
      drive(1, 1'b0, 16'h0, 5'd0, 0, 2'd2);
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("rst_busy", 32'(bz0), 32'd0);
      check("rst_cs",   32'(cs0), 32'hF);
      check("rst_sclk0", 32'(sc0), 32'd0);
      check("rst_sclk1", 32'(sc1), 32'd1);
      check("rst_rx",   32'(rx0), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0 loopback, full word.
      xfer(0, 16'hA5C3, 5'd16, 0, 2'd2, 0, bc, nl, bits, csf, rxd);
      check("t1_busy_cycles", 32'(bc), 32'd136);
      check("t1_rising_edges", 32'(nl), 32'd16);
      check("t1_mosi_bits", 32'(bits), 32'hA5C3);
      check("t1_rx", 32'(rxd), 32'hA5C3);
      repeat (3) @(negedge clk);

      // Mode 0, 8 bits, miso tied high.
      xfer(0, 16'h1234, 5'd8, 0, 2'd1, 0, bc, nl, bits, csf, rxd);
      check("t2_busy_cycles", 32'(bc), 32'd72);
      check("t2_mosi_bits", 32'(bits), 32'h0034);
      check("t2_rx", 32'(rxd), 32'h00FF);
      repeat (3) @(negedge clk);

      // CPOL=1 CPHA=1 LSB-first loopback.
      check("t3_sclk_idle", 32'(sc1), 32'd1);
      xfer(1, 16'h0001, 5'd4, 0, 2'd2, 0, bc, nl, bits, csf, rxd);
      check("t3_busy_cycles", 32'(bc), 32'd30);
      check("t3_falling_edges", 32'(nl), 32'd4);
      check("t3_mosi_bits", 32'(bits), 32'h0008);
      check("t3_rx", 32'(rxd), 32'h0001);
      repeat (3) @(negedge clk);

      // Chip select 2, then 3 requested in the done cycle.
      xfer(0, 16'h00C7, 5'd8, 2, 2'd0, 0, bc, nl, bits, csf, rxd);
      check("t4_cs_sel2", 32'(csf), 32'hB);
      check("t4_rx0", 32'(rxd), 32'h0000);
      xfer(0, 16'h0F0F, 5'd6, 3, 2'd2, 0, bc, nl, bits, csf, rxd);
      check("t4_cs_sel3", 32'(csf), 32'h7);
      check("t4_b2b_busy", 32'(bc), 32'd56);
      repeat (3) @(negedge clk);

      // Starts during busy and data_in churn must not disturb the latched word.
      xfer(0, 16'h5A5A, 5'd12, 1, 2'd2, 1, bc, nl, bits, csf, rxd);
      check("t5_rx_latched", 32'(rxd), 32'h0A5A);
      check("t5_busy_cycles", 32'(bc), 32'd104);
      repeat (3) @(negedge clk);

      // Zero-length start is ignored.
      drive(0, 1'b1, 16'hFFFF, 5'd0, 0, 2'd2);
      @(negedge clk);
      stop_start(0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (bz0 || dn0 || sc0) cnt++;
         @(negedge clk);
      end
      check("t5_len0_activity", 32'(cnt), 32'd0);

      // Over-long length saturates to the word width.
      xfer(0, 16'hBEEF, 5'd20, 0, 2'd2, 0, bc, nl, bits, csf, rxd);
      check("t5_sat_busy", 32'(bc), 32'd136);
      check("t5_sat_rx", 32'(rxd), 32'hBEEF);
      repeat (3) @(negedge clk);

      // Reset at bit 5 of a 16-bit transfer.
      drive(0, 1'b1, 16'hFFFF, 5'd16, 1, 2'd2);
      @(negedge clk);
      stop_start(0);
      repeat (44) @(negedge clk);
      check("t6_busy_before", 32'(bz0), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_cs", 32'(cs0), 32'hF);
      check("t6_sclk", 32'(sc0), 32'd0);
      check("t6_busy", 32'(bz0), 32'd0);
      check("t6_rx", 32'(rx0), 32'd0);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (dn0) cnt++;
      end
      check("t6_no_done", 32'(cnt), 32'd0);

      // Randomized transfers on both instances.
      for (int n = 0; n < 30; n++) begin
         int k, gap;
         k   = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         xfer(k, 16'($urandom), 5'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), bc, nl, bits, csf, rxd);
      end
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
